// File: rtl/combo_entry.sv
// ---------------------------------------------------------------------------
// combo_entry
//
// Code-entry front end for the combination lock. A raw active-low push-button
// is synchronised and debounced. Every accepted press captures the decimal
// digit presented on the switches. Once DIGITS digits have been collected,
// the assembled code is offered to the lock comparator over a valid/ready
// handshake.
//
// Parameters
//   DIGITS          digits per code (>= 2)
//   DIGIT_W         bits per digit
//   DEBOUNCE_CYCLES stable cycles before a new key level is accepted (>= 2)
//   TIMEOUT_CYCLES  idle cycles before a partial entry is abandoned
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   sw           digit value, sampled on an accepted press
//   key_n        raw asynchronous push-button, active-low
//   clr          synchronous abort of a partial entry
//   code         assembled code, first digit in the most significant digit
//   code_valid   code complete and offered
//   code_ready   consumer takes the code this cycle
//   digit_count  digits captured so far
//   entry_err    one-cycle pulse, press rejected because sw > 9
//   timed_out    one-cycle pulse, partial entry abandoned
//
// Build option
//   COMBO_ENTRY_TIMEOUT_EN  when defined, a partial entry that sees neither a
//                           digit nor clr for TIMEOUT_CYCLES is abandoned.
//                           When undefined, timed_out is tied low and partial
//                           entries persist.
// ---------------------------------------------------------------------------
module combo_entry #(
  parameter int DIGITS          = 4,
  parameter int DIGIT_W         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W-1:0]            sw,
  input  logic                          key_n,
  input  logic                          clr,
  output logic [DIGITS*DIGIT_W-1:0]     code,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(DIGITS+1)-1:0]   digit_count,
  output logic                          entry_err,
  output logic                          timed_out
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LAST_SLOT  = CNT_W'(DIGITS - 1);
  localparam logic [DIGIT_W-1:0] MAX_DIGIT  = DIGIT_W'(9);

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    SUBMIT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_sync1;
  logic                r_sync2;
  logic                r_db_level;
  logic [DB_W-1:0]     r_db_cnt;
  logic                r_armed;
  logic                r_press;

  logic [CODE_W-1:0]   r_code;
  logic [CNT_W-1:0]    r_count;
  logic                r_err;
  logic                r_to;

  logic                w_fall;
  logic                w_active;
  logic                w_digit_ok;
  logic                w_clear;
  logic                w_capture;
  logic                w_reject;
  logic                w_handshake;
  logic                w_last_digit;
  logic                w_timeout_hit;

  // Two-flop synchronizer. It is deliberately left out of reset so that a
  // key held down through reset is still seen as pressed afterwards, which
  // lets the arming logic below suppress that stale press.
  always_ff @(posedge clk) begin
    r_sync1 <= key_n;
    r_sync2 <= r_sync1;
  end

  // Debouncer: the accepted level follows the synchronized key only after
  // the two have disagreed for DEBOUNCE_CYCLES consecutive cycles. Any
  // agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
    end else if (r_sync2 != r_db_level) begin
      if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // The debounced level is about to go 1 -> 0 on this edge.
  assign w_fall = !r_sync2 && r_db_level && (r_db_cnt == DB_LAST);

  // A press only counts once the key has been seen released since reset.
  // The press pulse is registered, so a digit lands one cycle after the
  // debounced level falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      if (r_sync2 && r_db_level) begin
        r_armed <= 1'b1;
      end
      r_press <= w_fall && r_armed;
    end
  end

  // State register for the entry FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output and strobe decode. clr takes priority over a same-cycle press.
  // While the code is offered, presses and clr are ignored entirely.
  always_comb begin
    w_active     = (r_state != SUBMIT);
    w_digit_ok   = (sw <= MAX_DIGIT);
    w_clear      = w_active && clr;
    w_capture    = w_active && !clr && r_press && w_digit_ok;
    w_reject     = w_active && !clr && r_press && !w_digit_ok;
    w_handshake  = (r_state == SUBMIT) && code_ready;
    w_last_digit = (r_count == LAST_SLOT);
    code_valid   = (r_state == SUBMIT);
  end

  // Next-state logic. Filling the last slot moves straight to SUBMIT, so
  // code_valid rises on the same edge that writes the final digit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, ENTER: begin
        if (w_clear) begin
          w_state_next = IDLE;
        end else if (w_capture) begin
          w_state_next = w_last_digit ? SUBMIT : ENTER;
        end else if (w_timeout_hit) begin
          w_state_next = IDLE;
        end
      end
      SUBMIT: begin
        if (code_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Code and digit-count datapath plus the registered one-cycle pulses.
  // New digits shift in at the bottom, so the first digit entered ends up
  // in the most significant position of a complete code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_err <= w_reject;
      r_to  <= w_timeout_hit;
      if (w_clear || w_handshake || w_timeout_hit) begin
        r_code  <= '0;
        r_count <= '0;
      end else if (w_capture) begin
        r_code  <= {r_code[CODE_W-DIGIT_W-1:0], sw};
        r_count <= r_count + 1'b1;
      end
    end
  end

`ifdef COMBO_ENTRY_TIMEOUT_EN
  localparam int                TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;

  // Inactivity timer: runs only in ENTER and restarts on every accepted
  // digit. A rejected press does not count as activity. clr on the expiry
  // cycle wins, and so does a digit arriving on that cycle.
  assign w_timeout_hit = (r_state == ENTER) && !clr && !w_capture &&
                         (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if ((r_state != ENTER) || clr || w_capture || w_timeout_hit) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  // No inactivity timer in this build. A non-positive timeout is
  // meaningless, so this comparison is always false.
  assign w_timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign code        = r_code;
  assign digit_count = r_count;
  assign entry_err   = r_err;
  assign timed_out   = r_to;

endmodule

// File: tb/tb_combo_entry.sv
// ---------------------------------------------------------------------------
// tb_combo_entry
//
// Self-checking bench for combo_entry with a short debounce (4 cycles) and a
// 50-cycle timeout. A behavioural model keeps the entered digits in a queue
// and derives the expected outputs from it on every cycle. Directed checks
// with literal values pin the model to hand-computed results.
// ---------------------------------------------------------------------------
module tb_combo_entry;

  localparam int DIGITS   = 4;
  localparam int DIGIT_W  = 4;
  localparam int DEB      = 4;
  localparam int TIMEOUT  = 50;
`ifdef COMBO_ENTRY_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   sw = 4'd0;
  logic         key_n = 1'b1;
  logic         clr = 1'b0;
  logic [15:0]  code;
  logic         code_valid;
  logic         code_ready = 1'b0;
  logic [2:0]   digit_count;
  logic         entry_err;
  logic         timed_out;

  int errors = 0;
  int checks = 0;
  int errPulses = 0;
  int toPulses = 0;

  combo_entry #(
    .DIGITS(DIGITS),
    .DIGIT_W(DIGIT_W),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .key_n(key_n),
    .clr(clr),
    .code(code),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .digit_count(digit_count),
    .entry_err(entry_err),
    .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  mDigits[$];
  bit  mWin[$];
  bit  mSync1 = 1'b1;
  bit  mSync2 = 1'b1;
  bit  mLevel = 1'b1;
  bit  mArmed = 1'b0;
  bit  mPress = 1'b0;
  bit  mErr = 1'b0;
  bit  mTo = 1'b0;
  bit  mReady = 1'b0;
  bit  mCur;
  bit  mArmedBefore;
  bit  mNewPress;
  bit  mAllDiff;
  int  mCycle = 0;
  int  mLastCap = 0;

  function automatic logic [15:0] modelCode();
    logic [15:0] c;
    c = 16'h0000;
    foreach (mDigits[i]) c = (c << 4) | 16'(mDigits[i]);
    return c;
  endfunction

  // Model step per rising edge: a digit lands one cycle after the key has
  // been seen (through two sync stages) differing from the accepted level
  // for DEB straight cycles; the entry itself is just a queue of digits.
  always @(posedge clk) begin
    mCycle++;
    mCur = mSync2;
    if (rst) begin
      mDigits.delete();
      mWin.delete();
      mLevel = 1'b1;
      mArmed = 1'b0;
      mPress = 1'b0;
      mErr = 1'b0;
      mTo = 1'b0;
      mReady = 1'b1;
    end else begin
      mErr = 1'b0;
      mTo = 1'b0;
      if (mDigits.size() == DIGITS) begin
        if (code_ready) mDigits.delete();
      end else if (clr) begin
        mDigits.delete();
      end else if (mPress && sw <= 4'd9) begin
        mDigits.push_back(int'(sw));
        mLastCap = mCycle;
      end else begin
        if (mPress) mErr = 1'b1;
        if (TO_EN && mDigits.size() > 0 && (mCycle - mLastCap) == TIMEOUT) begin
          mDigits.delete();
          mTo = 1'b1;
        end
      end
      mArmedBefore = mArmed;
      if (mCur && mLevel) mArmed = 1'b1;
      mWin.push_back(mCur);
      if (mWin.size() > DEB) void'(mWin.pop_front());
      mAllDiff = (mWin.size() == DEB);
      foreach (mWin[i]) if (mWin[i] == mLevel) mAllDiff = 1'b0;
      mNewPress = 1'b0;
      if (mAllDiff) begin
        if (mLevel && mArmedBefore) mNewPress = 1'b1;
        mLevel = ~mLevel;
        mWin.delete();
      end
      mPress = mNewPress;
    end
    mSync2 = mSync1;
    mSync1 = key_n;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mReady) begin
      checkOutput("code", 32'(code), 32'(modelCode()));
      checkOutput("code_valid", 32'(code_valid), 32'(mDigits.size() == DIGITS));
      checkOutput("digit_count", 32'(digit_count), 32'(mDigits.size()));
      checkOutput("entry_err", 32'(entry_err), 32'(mErr));
      checkOutput("timed_out", 32'(timed_out), 32'(mTo));
    end
    if (entry_err) errPulses++;
    if (timed_out) toPulses++;
  end

  // ---------------- stimulus ----------------
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One clean press and release of the key with digit d on the switches.
  task automatic applyStimulus(input logic [3:0] d);
    sw = d;
    key_n = 1'b0;
    waitCycles(DEB + 6);
    key_n = 1'b1;
    waitCycles(DEB + 6);
  endtask

  int n;
  int base;

  initial begin
    waitCycles(5);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("reset code", 32'(code), 32'h0);
    checkOutput("reset valid", 32'(code_valid), 32'h0);
    checkOutput("reset count", 32'(digit_count), 32'h0);

    // Full code 1,2,3,4 and a single-cycle handshake.
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'd4);
    checkOutput("code 1234", 32'(code), 32'h1234);
    checkOutput("valid after 4", 32'(code_valid), 32'h1);
    checkOutput("count after 4", 32'(digit_count), 32'h4);
    code_ready = 1'b1;
    waitCycles(1);
    code_ready = 1'b0;
    checkOutput("valid after hs", 32'(code_valid), 32'h0);
    checkOutput("code after hs", 32'(code), 32'h0);
    checkOutput("count after hs", 32'(digit_count), 32'h0);

    // Short glitches are filtered, then a stable press lands after 7 edges.
    sw = 4'd5;
    for (int g = 0; g < 5; g++) begin
      key_n = 1'b0;
      waitCycles(3);
      key_n = 1'b1;
      waitCycles(3);
    end
    checkOutput("no capture on glitch", 32'(digit_count), 32'h0);
    key_n = 1'b0;
    n = 0;
    while (n < 20 && digit_count == 3'd0) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("press latency", 32'(n), 32'd7);
    waitCycles(5);
    key_n = 1'b1;
    waitCycles(DEB + 6);
    checkOutput("single capture", 32'(digit_count), 32'h1);
    checkOutput("code 5", 32'(code), 32'h5);
    clr = 1'b1;
    waitCycles(1);
    clr = 1'b0;

    // Two digits, then an invalid digit, then abort.
    applyStimulus(4'd7);
    applyStimulus(4'd5);
    base = errPulses;
    applyStimulus(4'd12);
    checkOutput("err pulses", 32'(errPulses - base), 32'd1);
    checkOutput("count after err", 32'(digit_count), 32'h2);
    checkOutput("code 75", 32'(code), 32'h0075);
    clr = 1'b1;
    waitCycles(1);
    clr = 1'b0;
    checkOutput("code after clr", 32'(code), 32'h0);
    checkOutput("count after clr", 32'(digit_count), 32'h0);

    // Offered code holds through presses and clr while not accepted.
    applyStimulus(4'd9);
    applyStimulus(4'd8);
    applyStimulus(4'd7);
    applyStimulus(4'd6);
    base = errPulses;
    applyStimulus(4'd3);
    applyStimulus(4'd12);
    clr = 1'b1;
    waitCycles(1);
    clr = 1'b0;
    waitCycles(3);
    checkOutput("held code", 32'(code), 32'h9876);
    checkOutput("held valid", 32'(code_valid), 32'h1);
    checkOutput("held count", 32'(digit_count), 32'h4);
    checkOutput("no err in submit", 32'(errPulses - base), 32'd0);
    code_ready = 1'b1;
    waitCycles(1);
    code_ready = 1'b0;
    checkOutput("drop after hs", 32'(code_valid), 32'h0);

    // Reset in the middle of a debounce with the key held throughout.
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    sw = 4'd4;
    key_n = 1'b0;
    waitCycles(4);
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(15);
    checkOutput("rst count", 32'(digit_count), 32'h0);
    checkOutput("rst code", 32'(code), 32'h0);
    checkOutput("rst valid", 32'(code_valid), 32'h0);
    key_n = 1'b1;
    waitCycles(10);
    applyStimulus(4'd4);
    checkOutput("capture after rearm", 32'(digit_count), 32'h1);
    checkOutput("code after rearm", 32'(code), 32'h4);
    clr = 1'b1;
    waitCycles(1);
    clr = 1'b0;

    // Partial entry left idle.
    base = toPulses;
    applyStimulus(4'd1);
    waitCycles(TIMEOUT);
    checkOutput("timeout pulses", 32'(toPulses - base), TO_EN ? 32'd1 : 32'd0);
    checkOutput("count after idle", 32'(digit_count), TO_EN ? 32'd0 : 32'd1);
    clr = 1'b1;
    waitCycles(1);
    clr = 1'b0;
    waitCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/combo_entry.md
# combo_entry

Sequential code-entry front end for the combination lock: debounces a raw push-button, captures one switch-encoded decimal digit per press, assembles a multi-digit code, and delivers it to the lock checker over a valid/ready handshake. It sits between the board switches/keys and the combination comparator, and is the submitting side of the code interface the comparator consumes.

## Interface
- DIGITS, 4: digits per code (≥2)
- DIGIT_W, 4: bits per digit
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles before a key level is accepted (≥2)
- TIMEOUT_CYCLES, 250000000: idle cycles before a partial entry is abandoned (used only with the timeout feature)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- sw  in  DIGIT_W  digit value, sampled on the accepted press
- key_n  in  1  raw asynchronous push-button, active-low
- clr  in  1  synchronous active-high abort of a partial entry
- code  out  DIGITS*DIGIT_W  assembled code; first digit entered in the MS digit
- code_valid  out  1  code is complete and offered
- code_ready  in  1  consumer accepts code this cycle
- digit_count  out  $clog2(DIGITS+1)  digits captured so far
- entry_err  out  1  one-cycle pulse: press rejected, sw > 9
- timed_out  out  1  one-cycle pulse: partial entry abandoned

## Operation
- Key path: key_n passes through a 2-flop synchronizer. Debounced level (reset 1) updates after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. Press event = debounced level 1→0, one-cycle internal pulse. Release generates nothing.
- States: IDLE (count 0), ENTER (0 < count < DIGITS), SUBMIT.
- IDLE/ENTER, press with sw ≤ 9: code ← {code[DIGITS*DIGIT_W-DIGIT_W-1:0], sw}, count+1. If new count = DIGITS → SUBMIT, else → ENTER.
- IDLE/ENTER, press with sw > 9: no capture, entry_err pulses, state/count unchanged (timeout counter not restarted).
- IDLE/ENTER, clr: code ← 0, count ← 0, → IDLE. clr beats a same-cycle press.
- SUBMIT: code_valid = 1, code and digit_count = DIGITS held stable. Presses and clr are ignored (no entry_err). On code_valid & code_ready: → IDLE, code ← 0, count ← 0.
- rst in any state, mid-debounce included: code 0, code_valid 0, digit_count 0, entry_err 0, timed_out 0, debounced level 1, debounce and timeout counters 0, state IDLE. A key held through reset release creates no press until it is released and then pressed again.

## Timing
- Press latency: key_n falling (stable) → capture in code/digit_count after 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- code_valid asserts on the same edge that writes the final digit. It drops on the edge after the handshake cycle. code_ready may be held high permanently, giving a one-cycle valid.
- code_ready while code_valid = 0 has no effect.
- entry_err and timed_out are registered, high exactly one cycle.
- Minimum spacing between accepted presses: 2*DEBOUNCE_CYCLES (press plus release).

## Configuration
- COMBO_ENTRY_TIMEOUT_EN defined: in ENTER, a counter clears on every accepted digit. When it reaches TIMEOUT_CYCLES without clr or a new digit, code ← 0, count ← 0, → IDLE, and timed_out pulses on that edge. The counter does not run in IDLE or SUBMIT. clr on the timeout cycle wins, with no pulse.
- Not defined: no counter is built, timed_out is constant 0, and partial entries persist indefinitely.

## Test plan
- DEBOUNCE_CYCLES=4: press/release with sw=1,2,3,4 → after the 4th capture, code=16'h1234, code_valid=1, digit_count=4. With code_ready=1 for 1 cycle → code_valid=0, code=0, digit_count=0 next cycle.
- key_n glitches low for 3 cycles, repeated 5×, then stable low → exactly one capture, at the cycle of 2+4+1 after the stable edge.
- Two digits 7,5 entered, then sw=12 pressed → entry_err one cycle, digit_count stays 2. Then clr → code=0, digit_count=0.
- Complete code 9,8,7,6 with code_ready=0 for 20 cycles plus extra presses and clr → code_valid stays 1, code=16'h9876 unchanged, no entry_err.
- rst asserted mid-debounce after 2 digits → all outputs 0, key held through reset gives no capture until released and pressed again.
- With COMBO_ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=50: enter 1 digit, then idle → timed_out pulses 50 cycles after capture, digit_count=0. Without the macro: digit_count stays 1 and timed_out stays 0.
